lsu_mem_ctrl: RTL

- Load/store initiator between the single-cycle MIPS datapath and the word-wide data memory. Memory has a combinational read, a synchronous write and only word writes.
- Accepts byte, halfword and word load/store requests.
- Issues word-indexed memory accesses.
- Performs read-modify-write for sub-word stores, with sign/zero extension for loads.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl
//  Purpose  : Load/store initiator for a word-wide data memory. Handles byte,
//             halfword and word accesses (RMW for sub-word stores) and flags
//             misaligned / out-of-range requests. Optional macro LSU_STAT_EN
//             adds load/store/fault completion counters.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        range_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
`ifdef LSU_STAT_EN
    ,
    output logic [15:0] ld_cnt,
    output logic [15:0] st_cnt,
    output logic [15:0] flt_cnt
`endif
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;
    localparam logic [1:0] c_ST_FAULT  = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_lane;
    logic        r_flt_mis;
    logic        r_done;
    logic        r_misalign;
    logic        r_range_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_wd;

    logic        w_accept;
    logic        w_misalign;
    logic        w_range;
    logic        w_word_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merge;

    assign w_accept   = req && (r_state == c_ST_IDLE);
    assign w_misalign = ((size == c_SZ_HALF) && addr[0])
                     || ((size == c_SZ_WORD) && (addr[1:0] != 2'b00))
                     || (size == 2'b11);
    assign w_range    = ({2'b00, addr[31:2]} >= c_MEM_WORDS);

    assign w_word_store = r_we && (r_size == c_SZ_WORD);

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        w_byte = mem_RD[7:0];
        case (r_lane)
            2'd0:    w_byte = mem_RD[7:0];
            2'd1:    w_byte = mem_RD[15:8];
            2'd2:    w_byte = mem_RD[23:16];
            default: w_byte = mem_RD[31:24];
        endcase
        w_half = r_lane[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (r_size)
            c_SZ_BYTE: w_ld_data = {{24{~r_uns & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_ld_data = {{16{~r_uns & w_half[15]}}, w_half};
            default:   w_ld_data = mem_RD;
        endcase
    end

    // Sub-word store merge; the latched store data still sits in r_mem_wd
    always_comb begin
        w_mask = 32'h0000_0000;
        w_ins  = 32'h0000_0000;
        case (r_size)
            c_SZ_BYTE: begin
                w_mask = 32'h0000_00FF << {r_lane, 3'b000};
                w_ins  = {4{r_mem_wd[7:0]}};
            end
            c_SZ_HALF: begin
                w_mask = r_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_ins  = {2{r_mem_wd[15:0]}};
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_ins  = r_mem_wd;
            end
        endcase
        w_merge = (mem_RD & ~w_mask) | (w_ins & w_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_lane      <= 2'b00;
            r_flt_mis   <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_range_err <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_mem_a     <= 32'h0000_0000;
            r_mem_wd    <= 32'h0000_0000;
        end else begin
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_range_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_we      <= we;
                        r_size    <= size;
                        r_uns     <= uns;
                        r_lane    <= addr[1:0];
                        r_flt_mis <= w_misalign;
                        r_mem_a   <= {2'b00, addr[31:2]};
                        r_mem_wd  <= wdata;
                        r_state   <= (w_misalign || w_range) ? c_ST_FAULT : c_ST_ACCESS;
                    end
                end
                c_ST_FAULT: begin
                    r_done      <= 1'b1;
                    r_misalign  <= r_flt_mis;
                    r_range_err <= ~r_flt_mis;
                    r_state     <= c_ST_IDLE;
                end
                c_ST_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_ld_data;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else if (w_word_store) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_mem_wd <= w_merge;
                        r_state  <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Write strobe decoded from state so an async reset kills it at once
    assign mem_WE    = ((r_state == c_ST_ACCESS) && w_word_store) || (r_state == c_ST_WRITE);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign misalign  = r_misalign;
    assign range_err = r_range_err;
    assign rdata     = r_rdata;
    assign mem_A     = r_mem_a;
    assign mem_WD    = r_mem_wd;

`ifdef LSU_STAT_EN
    logic [15:0] r_ld_cnt;
    logic [15:0] r_st_cnt;
    logic [15:0] r_flt_cnt;

    // Counters step on the same edge that raises done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_cnt  <= 16'h0000;
            r_st_cnt  <= 16'h0000;
            r_flt_cnt <= 16'h0000;
        end else begin
            if (r_state == c_ST_FAULT) begin
                r_flt_cnt <= r_flt_cnt + 16'h0001;
            end
            if ((r_state == c_ST_ACCESS) && !r_we) begin
                r_ld_cnt <= r_ld_cnt + 16'h0001;
            end
            if (((r_state == c_ST_ACCESS) && w_word_store) || (r_state == c_ST_WRITE)) begin
                r_st_cnt <= r_st_cnt + 16'h0001;
            end
        end
    end

    assign ld_cnt  = r_ld_cnt;
    assign st_cnt  = r_st_cnt;
    assign flt_cnt = r_flt_cnt;
`endif

endmodule
`default_nettype wire
